// File: rtl/io_peripheral_hub_pkg.sv
// Shared definitions for the I/O peripheral hub: register indices and status bit positions.
package io_defs;

    localparam logic [11:0] IDX_CNT_LO   = 12'd2;
    localparam logic [11:0] IDX_CNT_HI   = 12'd3;
    localparam logic [11:0] IDX_GPIO_OUT = 12'd16;
    localparam logic [11:0] IDX_GPIO_IN  = 12'd32;

    localparam int OVF   = 15;
    localparam int FULL  = 14;
    localparam int EMPTY = 13;

    // The console status reports at most 255 entries so deep FIFOs still fit the byte field.
    function automatic logic [7:0] sat_count8(input logic [8:0] count);
        return (count > 9'd255) ? 8'hFF : count[7:0];
    endfunction

endpackage

// File: rtl/io_peripheral_hub_sync_fifo.sv
// Single-clock FIFO with a combinational head; a pop frees a slot for a push in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    // Hold the head at zero while empty so the console data reads 0 out of reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage is not reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_peripheral_hub.sv
// Register-bus peripherals behind the core: console FIFO, halt flag, cycle counter and GPIO.
module io_peripheral_hub
    import io_defs::*;
#(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          NUM_CHANNELS  = 4,
    parameter logic [11:0] CONSOLE_INDEX = 12'd0,
    parameter logic [11:0] HALT_INDEX    = 12'd4095
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [11:0]                  i_register_index,
    input  logic                         i_register_read,
    input  logic                         i_register_write,
    input  logic [15:0]                  i_register_write_value,
    output logic [15:0]                  o_register_read_value,
    output logic                         o_console_valid,
    output logic [7:0]                   o_console_data,
    input  logic                         i_console_ready,
    output logic                         o_halted,
    output logic [16*NUM_CHANNELS-1:0]   o_gpio_out,
    input  logic [16*NUM_CHANNELS-1:0]   i_gpio_in
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]                 r_counter;
    logic [15:0]                 r_shadow;
    logic                        r_halted;
    logic                        r_overflow;
    logic [15:0]                 r_read_value;
    logic [16*NUM_CHANNELS-1:0]  r_gpio_out;
    logic [16*NUM_CHANNELS-1:0]  r_gpio_sync1;
    logic [16*NUM_CHANNELS-1:0]  r_gpio_sync2;

    logic                        w_push_req;
    logic                        w_pop;
    logic                        w_status_read;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [CW-1:0]               w_fifo_count;
    logic [7:0]                  w_fifo_head;
    logic [15:0]                 w_status;
    logic [15:0]                 w_rd_data;

    assign w_push_req    = i_register_write && (i_register_index == CONSOLE_INDEX);
    assign w_status_read = i_register_read && (i_register_index == CONSOLE_INDEX);
    assign w_pop         = o_console_valid && i_console_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push_req),
        .i_data  (i_register_write_value[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_console_valid       = !w_fifo_empty;
    assign o_console_data        = w_fifo_head;
    assign o_halted              = r_halted;
    assign o_gpio_out            = r_gpio_out;
    assign o_register_read_value = r_read_value;

    // Console status word built from the pre-pop FIFO state of this cycle.
    always_comb begin
        w_status        = '0;
        w_status[OVF]   = r_overflow;
        w_status[FULL]  = w_fifo_full;
        w_status[EMPTY] = w_fifo_empty;
        w_status[7:0]   = sat_count8(9'(w_fifo_count));
    end

    // Read decode; anything not matched below reads as zero.
    always_comb begin
        w_rd_data = '0;
        if (i_register_index == CONSOLE_INDEX) begin
            w_rd_data = w_status;
        end
        if (i_register_index == IDX_CNT_LO) begin
            w_rd_data = r_counter[15:0];
        end
        if (i_register_index == IDX_CNT_HI) begin
            w_rd_data = r_shadow;
        end
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (i_register_index == IDX_GPIO_OUT + 12'(k)) begin
                w_rd_data = r_gpio_out[16*k +: 16];
            end
            if (i_register_index == IDX_GPIO_IN + 12'(k)) begin
                w_rd_data = r_gpio_sync2[16*k +: 16];
            end
        end
    end

    // Read data register; holds between reads. A low-half counter read also latches the high half.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_value <= '0;
            r_shadow     <= '0;
        end else if (i_register_read) begin
            r_read_value <= w_rd_data;
            if (i_register_index == IDX_CNT_LO) begin
                r_shadow <= r_counter[31:16];
            end
        end
    end

    // Sticky halt and the free-running cycle counter it freezes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_halted  <= 1'b0;
            r_counter <= '0;
        end else begin
            if (i_register_write && (i_register_index == HALT_INDEX)) begin
                r_halted <= 1'b1;
            end
            if (!r_halted) begin
                r_counter <= r_counter + 32'd1;
            end
        end
    end

    // Overflow flag: a fresh drop wins over a clear from a status read in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (w_status_read) begin
            r_overflow <= 1'b0;
        end
    end

    // GPIO output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gpio_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                if (i_register_write && (i_register_index == IDX_GPIO_OUT + 12'(k))) begin
                    r_gpio_out[16*k +: 16] <= i_register_write_value;
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous GPIO inputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gpio_sync1 <= '0;
            r_gpio_sync2 <= '0;
        end else begin
            r_gpio_sync1 <= i_gpio_in;
            r_gpio_sync2 <= r_gpio_sync1;
        end
    end

endmodule
